// File: rtl/regbank_writer.sv
// regbank_writer: write side of the MIPS register bank.
// Holds 32 x DATA_W registers ($0 hardwired to zero) and takes writes
// through a valid/ready handshake. It tracks a per-register dirty bitmap.
// A bulk clear zeroes registers 1..31, one register per cycle.
// All registers are exported on a flat bus that feeds the 32:1 read muxes.
module regbank_writer #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 5,
   localparam int NREGS  = 1 << ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    clr_req,
   output logic                    busy,
   output logic                    clr_done,
   output logic [NREGS-1:0]        dirty,
   output logic [NREGS*DATA_W-1:0] regs_flat
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [DATA_W-1:0]   regs [NREGS];
   logic                wr_fire;

   assign wr_fire = wr_valid & wr_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake outputs. The sweep ends on the edge that zeroes the last register.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      wr_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            wr_ready = 1'b1;
            if (clr_req) state_d = CLEAR;
         end
         CLEAR: begin
            busy = 1'b1;
            if (clr_cnt == LAST_REG) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sweep counter and the one-cycle completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt  <= ADDR_W'(1);
         clr_done <= 1'b0;
      end else begin
         clr_done <= (state_q == CLEAR) && (clr_cnt == LAST_REG);
         if (state_q == IDLE) begin
            if (clr_req) clr_cnt <= ADDR_W'(1);
         end else if (clr_cnt != LAST_REG) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
         end
      end
   end

   // Register array and dirty bitmap. Writes and sweep steps never collide: wr_ready is low during CLEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this array is reset explicitly because an async reset must zero every register at once; storage normally left unreset would become a RAM instead.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         dirty <= '0;
      end else if (state_q == CLEAR) begin
         regs[clr_cnt]  <= '0;
         dirty[clr_cnt] <= 1'b0;
      end else if (wr_fire && (wr_addr != '0)) begin
         regs[wr_addr]  <= wr_data;
         dirty[wr_addr] <= 1'b1;
      end
   end

   // Flatten the array for the read muxes: reg i at [DATA_W*i +: DATA_W].
   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign regs_flat[DATA_W*g +: DATA_W] = regs[g];
   end

endmodule
